fpu_divsqrt_hs_monitor: RTL and testbench
=========================================

# fpu_divsqrt_hs_monitor

Synthesizable, parametrised runtime monitor for the FP div/sqrt issue/writeback handshake, generalising the single-channel "start while writeback pending" unreachable check to `NUM_CH` independent units. Each channel tracks its own outstanding operation and flags four protocol violations:

- simultaneous accept + writeback;
- double accept;
- orphan writeback;
- latency timeout.

Errors are reported through registered pulses, sticky flags, a saturating counter and first-error capture. It sits beside the FPU wrapper and is usable both in silicon debug and as a formal/simulation checker.

## Interface
Parameters:
- `NUM_CH`, default 1: number of monitored div/sqrt channels (≥1).
- `MAX_LAT`, default 32: maximum cycles from accept to writeback (≥2).
- `ERR_CNT_W`, default 8: width of the error event counter.

Ports:
- `clk_i`  in  1  clock; all state updates on its rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `en_i`  in  1  reporting enable; 0 suppresses error pulses, sticky flags, counter and capture, while FSM tracking continues.
- `clear_i`  in  1  synchronous clear of sticky flags, counter and first-error capture.
- `op_starting_i`  in  NUM_CH  per-channel op start request.
- `unit_ready_i`  in  NUM_CH  per-channel unit ready.
- `wb_i`  in  NUM_CH  per-channel writeback.
- `wb_vld_i`  in  NUM_CH  per-channel writeback valid qualifier.
- `busy_o`  out  NUM_CH  channel has an outstanding op (state BUSY or HUNG).
- `err_pulse_o`  out  NUM_CH  one-cycle error indication per channel.
- `err_sticky_o`  out  4*NUM_CH  sticky per-channel error codes; bit `4*c+code`.
- `err_cnt_o`  out  ERR_CNT_W  saturating count of channel-error events.
- `first_err_vld_o`  out  1  first-error capture valid.
- `first_err_ch_o`  out  max(1,$clog2(NUM_CH))  channel of first error.
- `first_err_code_o`  out  2  code of first error.

## Operation
Per-channel definitions:
- accept = `op_starting_i & unit_ready_i`.
- wbev = `wb_i & wb_vld_i`.

Error codes: 0 OVERLAP, 1 DOUBLE, 2 ORPHAN, 3 TIMEOUT.

Per-channel FSM {IDLE, BUSY, HUNG} with latency counter `lat` of width $clog2(MAX_LAT+1):
- Any state, accept & wbev: OVERLAP; next BUSY, `lat`=0.
- IDLE, accept only: next BUSY, `lat`=0.
- IDLE, wbev only: ORPHAN; stay IDLE.
- BUSY, wbev only: next IDLE.
- BUSY, accept only: DOUBLE; stay BUSY, `lat`=0.
- BUSY, no event: if `lat`==MAX_LAT-1, TIMEOUT and next HUNG; else `lat`+1.
- HUNG, wbev only: next IDLE, no error (late writeback already reported).
- HUNG, accept only: DOUBLE; next BUSY, `lat`=0.
- At most one code per channel per cycle, by construction.

Reporting (only when `en_i`=1):
- `err_pulse_o[c]` is set for one cycle.
- The sticky bit for that code is set.
- `err_cnt_o` adds the number of erroring channels that cycle, saturating at all-ones (no wrap).
- If `first_err_vld_o`=0, the capture takes the lowest-index erroring channel and its code, and sets valid.

`clear_i`:
- Zeroes the sticky flags, counter and capture.
- Does not touch FSMs or `busy_o`.
- An error in the same cycle as `clear_i` is recorded after the clear: sticky = that error only, counter = its increment, capture = that error.

Reset values: all outputs 0; FSMs IDLE; `lat` = 0.

Reset mid-operation: reset forces IDLE immediately and asynchronously. A writeback after reset release is therefore reported as ORPHAN.

## Timing
- Inputs are sampled at rising edge N. `err_pulse_o`, sticky, counter and capture update at edge N and are visible in cycle N+1. Latency is 1 cycle; no combinational input-to-output paths.
- `busy_o` reflects the FSM state after edge N.
- For an accept at edge k, a wbev at edges k+1 … k+MAX_LAT is legal.
- With no wbev through edge k+MAX_LAT, TIMEOUT is detected at edge k+MAX_LAT; the pulse is high in the next cycle.
- Back-to-back errors produce back-to-back pulses.
- `en_i` acts per cycle; a violation occurring while `en_i`=0 is never reported later.

## Test plan
- NUM_CH=1, MAX_LAT=4: accept at edge 1, wbev at edge 3 -> no errors; `busy_o`=1 in cycles 2–3, 0 from cycle 4.
- Accept and wbev same edge in IDLE -> `err_pulse_o`=1 for one cycle, `err_sticky_o`=4'b0001, `err_cnt_o`=1, capture ch 0 code 0, `busy_o`=1.
- MAX_LAT=4: accept at edge 1, no wbev -> TIMEOUT at edge 5 (sticky bit 3), `busy_o` stays 1. Then wbev at edge 8 -> IDLE, no ORPHAN.
- NUM_CH=4: ORPHAN on ch2 and DOUBLE on ch3 at the same edge -> `err_cnt_o`=2, capture ch 2 code 2, sticky bits 10 and 13 set.
- ERR_CNT_W=2: five single orphan events -> `err_cnt_o` saturates at 3. Then `clear_i` together with an orphan -> `err_cnt_o`=1, sticky = orphan only, capture re-armed to that event.
- `en_i`=0 during a double accept -> no pulse, sticky or count, but the FSM re-arms `lat`. Assert `rst_i` mid-BUSY, then wbev after release -> ORPHAN reported.

Source files
------------

// File: rtl/fpu_divsqrt_hs_monitor.sv
// Runtime monitor for the FP div/sqrt issue/writeback handshake.
// Each channel tracks one outstanding op and flags overlap, double accept,
// orphan writeback and latency timeout. Errors are reported as registered
// pulses, sticky per-code flags, a saturating event counter and a
// first-error capture.
module fpu_divsqrt_hs_monitor #(
    parameter int unsigned NUM_CH    = 1,
    parameter int unsigned MAX_LAT   = 32,
    parameter int unsigned ERR_CNT_W = 8,
    localparam int unsigned ChW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   en_i,
    input  logic                   clear_i,
    input  logic [NUM_CH-1:0]      op_starting_i,
    input  logic [NUM_CH-1:0]      unit_ready_i,
    input  logic [NUM_CH-1:0]      wb_i,
    input  logic [NUM_CH-1:0]      wb_vld_i,
    output logic [NUM_CH-1:0]      busy_o,
    output logic [NUM_CH-1:0]      err_pulse_o,
    output logic [4*NUM_CH-1:0]    err_sticky_o,
    output logic [ERR_CNT_W-1:0]   err_cnt_o,
    output logic                   first_err_vld_o,
    output logic [ChW-1:0]         first_err_ch_o,
    output logic [1:0]             first_err_code_o
);

    localparam int unsigned LatW = $clog2(MAX_LAT + 1);
    // Wide enough to hold the counter plus one cycle's worth of increments.
    localparam int unsigned SumW = ERR_CNT_W + $clog2(NUM_CH + 1);

    localparam logic [1:0] CodeOverlap = 2'd0;
    localparam logic [1:0] CodeDouble  = 2'd1;
    localparam logic [1:0] CodeOrphan  = 2'd2;
    localparam logic [1:0] CodeTimeout = 2'd3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StHung = 2'd2
    } state_e;

    state_e              state_q [NUM_CH];
    state_e              state_d [NUM_CH];
    logic [LatW-1:0]     lat_q   [NUM_CH];
    logic [LatW-1:0]     lat_d   [NUM_CH];

    logic [NUM_CH-1:0]   accept;
    logic [NUM_CH-1:0]   wbev;
    logic [NUM_CH-1:0]   err;
    logic [1:0]          code    [NUM_CH];
    logic [NUM_CH-1:0]   err_en;

    logic [NUM_CH-1:0]   pulse_q;
    logic [4*NUM_CH-1:0] sticky_q, sticky_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
    logic                first_vld_q, first_vld_d;
    logic [ChW-1:0]      first_ch_q, first_ch_d;
    logic [1:0]          first_code_q, first_code_d;
    logic [SumW-1:0]     cnt_sum;

    assign accept = op_starting_i & unit_ready_i;
    assign wbev   = wb_i & wb_vld_i;
    assign err_en = en_i ? err : '0;

    // Per-channel next-state, latency counter and error classification.
    always_comb begin
        for (int c = 0; c < int'(NUM_CH); c++) begin
            state_d[c] = state_q[c];
            lat_d[c]   = lat_q[c];
            err[c]     = 1'b0;
            code[c]    = CodeOverlap;
            if (accept[c] && wbev[c]) begin
                err[c]     = 1'b1;
                code[c]    = CodeOverlap;
                state_d[c] = StBusy;
                lat_d[c]   = '0;
            end else if (accept[c]) begin
                if (state_q[c] != StIdle) begin
                    err[c]  = 1'b1;
                    code[c] = CodeDouble;
                end
                state_d[c] = StBusy;
                lat_d[c]   = '0;
            end else if (wbev[c]) begin
                if (state_q[c] == StIdle) begin
                    err[c]  = 1'b1;
                    code[c] = CodeOrphan;
                end else begin
                    // A late writeback out of HUNG was already reported as a timeout.
                    state_d[c] = StIdle;
                    lat_d[c]   = '0;
                end
            end else if (state_q[c] == StBusy) begin
                if (lat_q[c] == LatW'(MAX_LAT - 1)) begin
                    err[c]     = 1'b1;
                    code[c]    = CodeTimeout;
                    state_d[c] = StHung;
                end else begin
                    lat_d[c] = lat_q[c] + LatW'(1);
                end
            end
        end
    end

    // Reporting next-state: a same-cycle clear is applied before new errors land.
    always_comb begin
        sticky_d     = clear_i ? '0 : sticky_q;
        first_vld_d  = clear_i ? 1'b0 : first_vld_q;
        first_ch_d   = clear_i ? '0 : first_ch_q;
        first_code_d = clear_i ? 2'd0 : first_code_q;
        cnt_sum      = clear_i ? '0 : SumW'(cnt_q);

        for (int c = 0; c < int'(NUM_CH); c++) begin
            if (err_en[c]) begin
                sticky_d[4*c + int'(code[c])] = 1'b1;
                cnt_sum = cnt_sum + SumW'(1);
            end
        end

        if (cnt_sum > {{(SumW - ERR_CNT_W){1'b0}}, {ERR_CNT_W{1'b1}}}) begin
            cnt_d = '1;
        end else begin
            cnt_d = cnt_sum[ERR_CNT_W-1:0];
        end

        // Descending scan so the lowest erroring channel wins.
        if (!first_vld_d && (err_en != '0)) begin
            for (int c = int'(NUM_CH) - 1; c >= 0; c--) begin
                if (err_en[c]) begin
                    first_ch_d   = ChW'(c);
                    first_code_d = code[c];
                end
            end
            first_vld_d = 1'b1;
        end
    end

    // Channel FSM state and latency counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                state_q[c] <= StIdle;
                lat_q[c]   <= '0;
            end
        end else begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                state_q[c] <= state_d[c];
                lat_q[c]   <= lat_d[c];
            end
        end
    end

    // Registered error reporting.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pulse_q      <= '0;
            sticky_q     <= '0;
            cnt_q        <= '0;
            first_vld_q  <= 1'b0;
            first_ch_q   <= '0;
            first_code_q <= 2'd0;
        end else begin
            pulse_q      <= err_en;
            sticky_q     <= sticky_d;
            cnt_q        <= cnt_d;
            first_vld_q  <= first_vld_d;
            first_ch_q   <= first_ch_d;
            first_code_q <= first_code_d;
        end
    end

    // Output mapping.
    always_comb begin
        for (int c = 0; c < int'(NUM_CH); c++) begin
            busy_o[c] = (state_q[c] != StIdle);
        end
    end

    assign err_pulse_o      = pulse_q;
    assign err_sticky_o     = sticky_q;
    assign err_cnt_o        = cnt_q;
    assign first_err_vld_o  = first_vld_q;
    assign first_err_ch_o   = first_ch_q;
    assign first_err_code_o = first_code_q;

endmodule

// File: tb/tb_fpu_divsqrt_hs_monitor.sv
// Directed bench for fpu_divsqrt_hs_monitor with 4 channels, MAX_LAT=4 and a
// 2-bit error counter so saturation is reachable quickly.
module tb_fpu_divsqrt_hs_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        clr;
    logic [3:0]  op, rdy, wb, vld;
    logic [3:0]  busy, pulse;
    logic [15:0] sticky;
    logic [1:0]  cnt;
    logic        fvld;
    logic [1:0]  fch;
    logic [1:0]  fcode;

    int total  = 0;
    int passed = 0;

    fpu_divsqrt_hs_monitor #(
        .NUM_CH    (4),
        .MAX_LAT   (4),
        .ERR_CNT_W (2)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .en_i             (en),
        .clear_i          (clr),
        .op_starting_i    (op),
        .unit_ready_i     (rdy),
        .wb_i             (wb),
        .wb_vld_i         (vld),
        .busy_o           (busy),
        .err_pulse_o      (pulse),
        .err_sticky_o     (sticky),
        .err_cnt_o        (cnt),
        .first_err_vld_o  (fvld),
        .first_err_ch_o   (fch),
        .first_err_code_o (fcode)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic chk_cap(input string tag, input logic v, input logic [1:0] ch,
                           input logic [1:0] cd);
        chk({tag, "_vld"}, 32'(fvld), 32'(v));
        chk({tag, "_ch"}, 32'(fch), 32'(ch));
        chk({tag, "_code"}, 32'(fcode), 32'(cd));
    endtask

    // Advance one edge, then drop single-cycle stimulus.
    task automatic step();
        @(posedge clk);
        #1;
        op  = '0;
        rdy = '0;
        wb  = '0;
        vld = '0;
        clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; clr = 1'b0;
        op = '0; rdy = '0; wb = '0; vld = '0;
        #3;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_pulse", 32'(pulse), 32'h0);
        chk("rst_sticky", 32'(sticky), 32'h0);
        chk("rst_cnt", 32'(cnt), 32'h0);
        chk_cap("rst_cap", 1'b0, 2'd0, 2'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Legal accept/writeback on ch0; start without ready and wb without valid ignored.
        op[0] = 1'b1; rdy[0] = 1'b1; step();
        chk("t1_busy_a", 32'(busy), 32'h1);
        chk("t1_pulse_a", 32'(pulse), 32'h0);
        op[1] = 1'b1; wb[2] = 1'b1; step();
        chk("t1_busy_b", 32'(busy), 32'h1);
        chk("t1_noqual", 32'(pulse), 32'h0);
        wb[0] = 1'b1; vld[0] = 1'b1; step();
        chk("t1_busy_c", 32'(busy), 32'h0);
        chk("t1_pulse_c", 32'(pulse), 32'h0);
        chk("t1_sticky", 32'(sticky), 32'h0);
        chk("t1_cnt", 32'(cnt), 32'h0);
        chk("t1_fvld", 32'(fvld), 32'h0);

        // Overlap in IDLE on ch0.
        op[0] = 1'b1; rdy[0] = 1'b1; wb[0] = 1'b1; vld[0] = 1'b1; step();
        chk("t2_pulse", 32'(pulse), 32'h1);
        chk("t2_sticky", 32'(sticky), 32'h0001);
        chk("t2_cnt", 32'(cnt), 32'h1);
        chk_cap("t2_cap", 1'b1, 2'd0, 2'd0);
        chk("t2_busy", 32'(busy), 32'h1);
        step();
        chk("t2_pulse_off", 32'(pulse), 32'h0);
        wb[0] = 1'b1; vld[0] = 1'b1; step();
        chk("t2_idle", 32'(busy), 32'h0);
        clr = 1'b1; step();
        chk("t2_clr_sticky", 32'(sticky), 32'h0);
        chk("t2_clr_cnt", 32'(cnt), 32'h0);
        chk("t2_clr_fvld", 32'(fvld), 32'h0);

        // Timeout on ch1: accept at edge 1, timeout at edge 5, late wb at edge 8.
        op[1] = 1'b1; rdy[1] = 1'b1; step();
        chk("t3_busy", 32'(busy), 32'h2);
        step(); step(); step();
        chk("t3_no_early", 32'(pulse), 32'h0);
        step();
        chk("t3_pulse", 32'(pulse), 32'h2);
        chk("t3_sticky", 32'(sticky), 32'h0080);
        chk("t3_cnt", 32'(cnt), 32'h1);
        chk_cap("t3_cap", 1'b1, 2'd1, 2'd3);
        chk("t3_hung_busy", 32'(busy), 32'h2);
        step();
        chk("t3_pulse_off", 32'(pulse), 32'h0);
        step();
        wb[1] = 1'b1; vld[1] = 1'b1; step();
        chk("t3_late_busy", 32'(busy), 32'h0);
        chk("t3_late_pulse", 32'(pulse), 32'h0);
        chk("t3_late_sticky", 32'(sticky), 32'h0080);
        clr = 1'b1; step();

        // Orphan on ch2 and double on ch3 at the same edge.
        op[3] = 1'b1; rdy[3] = 1'b1; step();
        chk("t4_busy_a", 32'(busy), 32'h8);
        wb[2] = 1'b1; vld[2] = 1'b1; op[3] = 1'b1; rdy[3] = 1'b1; step();
        chk("t4_pulse", 32'(pulse), 32'hC);
        chk("t4_cnt", 32'(cnt), 32'h2);
        chk("t4_sticky", 32'(sticky), 32'h2400);
        chk_cap("t4_cap", 1'b1, 2'd2, 2'd2);
        chk("t4_busy_b", 32'(busy), 32'h8);
        wb[3] = 1'b1; vld[3] = 1'b1; step();
        chk("t4_idle", 32'(busy), 32'h0);
        clr = 1'b1; step();

        // Five back-to-back orphans on ch0 saturate the 2-bit counter.
        for (int i = 1; i <= 5; i++) begin
            wb[0] = 1'b1; vld[0] = 1'b1; step();
            chk($sformatf("t5_pulse%0d", i), 32'(pulse), 32'h1);
            chk($sformatf("t5_cnt%0d", i), 32'(cnt), (i > 3) ? 32'd3 : 32'(i));
        end
        chk_cap("t5_cap", 1'b1, 2'd0, 2'd2);
        clr = 1'b1; wb[1] = 1'b1; vld[1] = 1'b1; step();
        chk("t5_clr_cnt", 32'(cnt), 32'h1);
        chk("t5_clr_sticky", 32'(sticky), 32'h0040);
        chk_cap("t5_rearm", 1'b1, 2'd1, 2'd2);
        wb[0] = 1'b1; vld[0] = 1'b1; step();
        chk("t5_cnt2", 32'(cnt), 32'h2);
        chk_cap("t5_keep", 1'b1, 2'd1, 2'd2);
        wb[1:0] = 2'b11; vld[1:0] = 2'b11; step();
        chk("t5_pair_pulse", 32'(pulse), 32'h3);
        chk("t5_pair_sat", 32'(cnt), 32'h3);
        clr = 1'b1; step();
        chk("t5_clr_again", 32'(cnt), 32'h0);

        // Double accept with reporting disabled still restarts the latency count.
        op[0] = 1'b1; rdy[0] = 1'b1; step();
        step(); step();
        en = 1'b0;
        op[0] = 1'b1; rdy[0] = 1'b1; step();
        chk("t6_dis_pulse", 32'(pulse), 32'h0);
        chk("t6_dis_sticky", 32'(sticky), 32'h0);
        chk("t6_dis_cnt", 32'(cnt), 32'h0);
        chk("t6_dis_fvld", 32'(fvld), 32'h0);
        chk("t6_dis_busy", 32'(busy), 32'h1);
        en = 1'b1;
        step(); step(); step();
        chk("t6_rearm", 32'(pulse), 32'h0);
        chk("t6_rearm_sticky", 32'(sticky), 32'h0);
        step();
        chk("t6_timeout", 32'(pulse), 32'h1);
        chk("t6_to_sticky", 32'(sticky), 32'h0008);
        chk("t6_hung", 32'(busy), 32'h1);

        // Asynchronous reset mid-operation, then orphan writeback.
        #2 rst = 1'b1;
        #1;
        chk("t6_async_busy", 32'(busy), 32'h0);
        chk("t6_async_sticky", 32'(sticky), 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        wb[0] = 1'b1; vld[0] = 1'b1; step();
        chk("t6_orph_pulse", 32'(pulse), 32'h1);
        chk("t6_orph_sticky", 32'(sticky), 32'h0004);
        chk("t6_orph_cnt", 32'(cnt), 32'h1);
        chk_cap("t6_orph_cap", 1'b1, 2'd0, 2'd2);
        chk("t6_orph_busy", 32'(busy), 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
